// File: rtl/sync_fifo_ring.sv
// sync_fifo_ring
//   Single-clock circular-buffer FIFO with valid/ready handshakes on both
//   sides. It is an elastic buffer between a streaming producer and a
//   consumer in the same clock domain.
//
// Parameters
//   DATA_WIDTH  width of a data word
//   FIFO_DEPTH  capacity in entries (power of two, >= 4)
//   CNT_WIDTH   width of the count/threshold ports, holds 0..FIFO_DEPTH
//   OUT_REG     0: head word read straight from memory (first-word-fall-through)
//               1: head word held in an extra output register
//
// Ports
//   i_clk, i_rst_n                clock, asynchronous active-low reset
//   i_clr                         synchronous flush (empties FIFO, clears watermark)
//   i_valid_s / o_ready_s         producer handshake, push = i_valid_s & o_ready_s
//   i_datain                      write data
//   o_valid_m / i_ready_m         consumer handshake, pop = o_valid_m & i_ready_m
//   o_dataout                     head-of-FIFO data
//   i_almostfull_lvl              o_almostfull asserted when count >= level
//   i_almostempty_lvl             o_almostempty asserted when count <= level
//   o_full, o_empty               count == FIFO_DEPTH, count == 0
//   o_almostfull, o_almostempty   threshold flags
//   o_count                       entries held (includes the output register)
//   o_max_count                   peak o_count since reset or flush
module sync_fifo_ring #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 256,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int OUT_REG    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_valid_s,
    output logic                  o_ready_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_valid_m,
    input  logic                  i_ready_m,
    output logic [DATA_WIDTH-1:0] o_dataout,
    input  logic [CNT_WIDTH-1:0]  i_almostfull_lvl,
    input  logic [CNT_WIDTH-1:0]  i_almostempty_lvl,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almostfull,
    output logic                  o_almostempty,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic [CNT_WIDTH-1:0]  o_max_count
);

    localparam int                   PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic [CNT_WIDTH-1:0]  max_q;
    logic                  push;
    logic                  pop;
    logic                  mem_rd;   // a word leaves the memory this cycle

    assign o_ready_s = (cnt_q != DEPTH_C);
    assign push      = i_valid_s && o_ready_s;
    assign pop       = o_valid_m && i_ready_m;

    // cnt_q counts every held word, including one parked in the output register
    always_comb begin
        cnt_nxt = cnt_q;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_nxt = cnt_q - CNT_WIDTH'(1);
            default: cnt_nxt = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            max_q  <= '0;
        end else if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            max_q  <= '0;
        end else begin
            // pointers are exactly log2(depth) bits wide, so they wrap on their own
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt_q <= cnt_nxt;
            max_q <= (cnt_nxt > max_q) ? cnt_nxt : max_q;
        end
    end

    // storage is deliberately left out of reset and flush
    always_ff @(posedge i_clk) begin
        if (push && !i_clr) begin
            mem[wr_ptr] <= i_datain;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_fwft
            assign o_valid_m = (cnt_q != '0);
            assign mem_rd    = pop;
            // memory is not reset, so mask the read path while nothing is held
            assign o_dataout = o_valid_m ? mem[rd_ptr] : '0;
        end else begin : g_oreg
            logic                  vld_p1;
            logic [DATA_WIDTH-1:0] dout_p1;
            logic                  mem_has;

            assign mem_has   = ((cnt_q - CNT_WIDTH'(vld_p1)) != '0);
            // refill when the register is empty or its word is being taken
            assign mem_rd    = mem_has && (!vld_p1 || pop);
            assign o_valid_m = vld_p1;
            assign o_dataout = dout_p1;

            // ---- output register stage ----
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_p1  <= 1'b0;
                    dout_p1 <= '0;
                end else if (i_clr) begin
                    vld_p1  <= 1'b0;
                    dout_p1 <= '0;
                end else if (mem_rd) begin
                    vld_p1  <= 1'b1;
                    dout_p1 <= mem[rd_ptr];
                end else if (pop) begin
                    vld_p1  <= 1'b0;   // data word is kept visible
                end
            end
        end
    endgenerate

    assign o_full        = (cnt_q == DEPTH_C);
    assign o_empty       = (cnt_q == '0);
    assign o_almostfull  = (cnt_q >= i_almostfull_lvl);
    assign o_almostempty = (cnt_q <= i_almostempty_lvl);
    assign o_count       = cnt_q;
    assign o_max_count   = max_q;

endmodule

// File: tb/tb_sync_fifo_ring.sv
module tb_sync_fifo_ring;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       valid_s;
    logic       ready_m;
    logic [7:0] datain;
    logic [3:0] af_lvl;
    logic [3:0] ae_lvl;

    logic       r0, v0, full0, empty0, af0, ae0;
    logic [7:0] d0;
    logic [3:0] cnt0, max0;
    logic       r1, v1, full1, empty1, af1, ae1;
    logic [7:0] d1;
    logic [3:0] cnt1, max1;

    int checks = 0;
    int errors = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    sync_fifo_ring #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .OUT_REG(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
        .i_valid_s(valid_s), .o_ready_s(r0), .i_datain(datain),
        .o_valid_m(v0), .i_ready_m(ready_m), .o_dataout(d0),
        .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl),
        .o_full(full0), .o_empty(empty0), .o_almostfull(af0), .o_almostempty(ae0),
        .o_count(cnt0), .o_max_count(max0)
    );

    sync_fifo_ring #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .OUT_REG(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
        .i_valid_s(valid_s), .o_ready_s(r1), .i_datain(datain),
        .o_valid_m(v1), .i_ready_m(ready_m), .o_dataout(d1),
        .i_almostfull_lvl(af_lvl), .i_almostempty_lvl(ae_lvl),
        .o_full(full1), .o_empty(empty1), .o_almostfull(af1), .o_almostempty(ae1),
        .o_count(cnt1), .o_max_count(max1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: record accepted words, compare on each accepted pop.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count0_vs_sb", 32'(cnt0), 32'(q0.size()));
            if (clr) begin
                q0.delete();
            end else begin
                if (v0 && ready_m) begin
                    if (q0.size() == 0) check("pop0_unexpected", 32'(d0), 32'hFFFF_FFFF);
                    else check("data0", 32'(d0), 32'(q0.pop_front()));
                end
                if (valid_s && r0) q0.push_back(datain);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("count1_vs_sb", 32'(cnt1), 32'(q1.size()));
            if (clr) begin
                q1.delete();
            end else begin
                if (v1 && ready_m) begin
                    if (q1.size() == 0) check("pop1_unexpected", 32'(d1), 32'hFFFF_FFFF);
                    else check("data1", 32'(d1), 32'(q1.pop_front()));
                end
                if (valid_s && r1) q1.push_back(datain);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count0"}, 32'(cnt0), 32'd0);
        check({tag, "_max0"},   32'(max0), 32'd0);
        check({tag, "_empty0"}, 32'(empty0), 32'd1);
        check({tag, "_full0"},  32'(full0), 32'd0);
        check({tag, "_ready0"}, 32'(r0), 32'd1);
        check({tag, "_valid0"}, 32'(v0), 32'd0);
        check({tag, "_dout0"},  32'(d0), 32'd0);
        check({tag, "_ae0"},    32'(ae0), 32'd1);
        check({tag, "_count1"}, 32'(cnt1), 32'd0);
        check({tag, "_valid1"}, 32'(v1), 32'd0);
        check({tag, "_dout1"},  32'(d1), 32'd0);
        check({tag, "_ready1"}, 32'(r1), 32'd1);
    endtask

    // push/pop table for the wrap test, count stays within 3..6
    logic [1:0] wrap_tab [20] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10,
                                  2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11};

    initial begin
        int         expc;
        logic [7:0] dctr;
        logic [1:0] ent;

        rst_n = 1'b0; clr = 1'b0; valid_s = 1'b0; ready_m = 1'b0;
        datain = 8'h00; af_lvl = 4'd0; ae_lvl = 4'd2;

        // reset state, almost-full threshold 0 makes the flag set out of reset
        #2;
        check_reset_outputs("rst");
        check("rst_af0_lvl0", 32'(af0), 32'd1);
        check("rst_af1_lvl0", 32'(af1), 32'd1);
        af_lvl = 4'd6;
        #1;
        check("rst_af0_lvl6", 32'(af0), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // fill 0x01..0x08 with the consumer stalled
        valid_s = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            datain = 8'(i);
            tick();
            check("fill_count0", 32'(cnt0), 32'(i));
            check("fill_count1", 32'(cnt1), 32'(i));
            check("fill_full0",  32'(full0), 32'(i == 8));
            check("fill_ready0", 32'(r0), 32'(i != 8));
            check("fill_af0",    32'(af0), 32'(i >= 6));
            check("fill_ae0",    32'(ae0), 32'(i <= 2));
        end
        check("fill_full1", 32'(full1), 32'd1);
        datain = 8'h09;
        tick();
        check("ninth_count0", 32'(cnt0), 32'd8);
        check("ninth_count1", 32'(cnt1), 32'd8);
        valid_s = 1'b0;
        ready_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick();
            check("drain_count0", 32'(cnt0), 32'(i));
            if (i == 7) check("ready_after_pop0", 32'(r0), 32'd1);
        end
        check("drain_empty0", 32'(empty0), 32'd1);
        check("drain_valid0", 32'(v0), 32'd0);
        check("drain_empty1", 32'(empty1), 32'd1);
        check("max0_peak", 32'(max0), 32'd8);

        // push+pop at count 0: only the push happens
        valid_s = 1'b1; ready_m = 1'b1; datain = 8'h10;
        tick();
        check("pp_empty_count0", 32'(cnt0), 32'd1);
        check("pp_empty_count1", 32'(cnt1), 32'd1);
        ready_m = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            datain = 8'(8'h10 + i);
            tick();
        end
        check("pp_mid_head0", 32'(d0), 32'h10);
        valid_s = 1'b1; ready_m = 1'b1; datain = 8'h14;
        tick();
        check("pp_mid_count0", 32'(cnt0), 32'd4);
        check("pp_mid_count1", 32'(cnt1), 32'd4);
        check("pp_mid_head0_adv", 32'(d0), 32'h11);
        check("pp_mid_head1_adv", 32'(d1), 32'h11);
        ready_m = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            datain = 8'(8'h10 + i);
            tick();
        end
        check("pp_full_pre0", 32'(full0), 32'd1);
        // thresholds beyond the depth: almost-full never, almost-empty always
        af_lvl = 4'd9; ae_lvl = 4'd9;
        #1;
        check("lvl9_af0", 32'(af0), 32'd0);
        check("lvl9_ae0", 32'(ae0), 32'd1);
        af_lvl = 4'd6; ae_lvl = 4'd2;
        // push+pop at full: only the pop happens
        valid_s = 1'b1; ready_m = 1'b1; datain = 8'h19;
        tick();
        check("pp_full_count0", 32'(cnt0), 32'd7);
        check("pp_full_count1", 32'(cnt1), 32'd7);
        valid_s = 1'b0;
        repeat (7) tick();
        check("pp_drain_empty0", 32'(empty0), 32'd1);
        check("pp_drain_empty1", 32'(empty1), 32'd1);

        // pointer wrap: preload 4 then run the table
        dctr = 8'h20; ready_m = 1'b0; valid_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            datain = dctr; dctr++;
            tick();
        end
        expc = 4;
        for (int i = 0; i < 20; i++) begin
            ent = wrap_tab[i];
            valid_s = ent[1]; ready_m = ent[0]; datain = dctr;
            if (ent[1]) dctr++;
            tick();
            expc = expc + int'(ent[1]) - int'(ent[0]);
            check("wrap_count0", 32'(cnt0), 32'(expc));
        end
        valid_s = 1'b0; ready_m = 1'b1;
        repeat (6) tick();
        check("wrap_empty0", 32'(empty0), 32'd1);
        check("wrap_empty1", 32'(empty1), 32'd1);

        // flush while the producer is still offering data
        ready_m = 1'b0; valid_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            datain = 8'(8'h40 + i);
            tick();
        end
        check("preclr_count0", 32'(cnt0), 32'd5);
        clr = 1'b1; datain = 8'h45;
        tick();
        clr = 1'b0; valid_s = 1'b0;
        check("clr_count0", 32'(cnt0), 32'd0);
        check("clr_empty0", 32'(empty0), 32'd1);
        check("clr_max0",   32'(max0), 32'd0);
        check("clr_count1", 32'(cnt1), 32'd0);
        check("clr_valid1", 32'(v1), 32'd0);

        // output-register latency: one cycle vs two cycles
        valid_s = 1'b1; datain = 8'hAA;
        tick();
        valid_s = 1'b0;
        check("lat_valid0_t1", 32'(v0), 32'd1);
        check("lat_dout0_t1",  32'(d0), 32'hAA);
        check("lat_valid1_t1", 32'(v1), 32'd0);
        tick();
        check("lat_valid1_t2", 32'(v1), 32'd1);
        check("lat_dout1_t2",  32'(d1), 32'hAA);
        ready_m = 1'b1;
        tick();
        ready_m = 1'b0;
        check("hold_valid1", 32'(v1), 32'd0);
        check("hold_dout1",  32'(d1), 32'hAA);

        // random stalls on both sides
        dctr = 8'h60;
        for (int i = 0; i < 60; i++) begin
            valid_s = 1'($urandom_range(0, 1));
            ready_m = 1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'(i % 7 != 0);
            datain = dctr; dctr++;
            tick();
        end
        valid_s = 1'b0; ready_m = 1'b1;
        repeat (12) tick();
        check("rand_empty0", 32'(empty0), 32'd1);
        check("rand_empty1", 32'(empty1), 32'd1);

        // asynchronous reset in the middle of a transfer
        ready_m = 1'b0; valid_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            datain = 8'(8'h80 + i);
            tick();
        end
        ready_m = 1'b1;
        #2 rst_n = 1'b0;
        valid_s = 1'b0; ready_m = 1'b0;
        q0.delete(); q1.delete();
        #1;
        check_reset_outputs("async");
        tick();
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_empty0", 32'(empty0), 32'd1);

        check("final_sb0", 32'(q0.size()), 32'd0);
        check("final_sb1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
